// File: rtl/chip8_frame_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chip8_frame_streamer                                                     |
// | Snapshots the CHIP-8 display into a shadow buffer and streams it         |
// | row-major as BEAT-pixel beats with SOF/EOL/EOF markers.                  |
// | Optional: CHIP8_FRAME_DIFF_EN skips frames identical to the last capture.|
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module chip8_frame_streamer #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 32,
  parameter int BEAT   = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [WIDTH*HEIGHT-1:0]                   display,
  input  logic                                      snap,
  output logic [BEAT-1:0]                           out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      out_sof,
  output logic                                      out_eol,
  output logic                                      out_eof,
  output logic [(HEIGHT > 1 ? $clog2(HEIGHT) : 1)-1:0] out_row,
  output logic                                      busy,
  output logic                                      snap_drop,
`ifdef CHIP8_FRAME_DIFF_EN
  output logic                                      frame_skip,
`endif
  output logic [15:0]                               frame_count,
  output logic [7:0]                                drop_count
);

  localparam int c_total  = WIDTH * HEIGHT;
  localparam int c_nbeats = c_total / BEAT;
  localparam int c_bpr    = WIDTH / BEAT;
  localparam int c_kw     = (c_nbeats > 1) ? $clog2(c_nbeats) : 1;
  localparam int c_rw     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [c_kw-1:0] c_last = c_kw'(c_nbeats - 1);

  generate
    if ((WIDTH % BEAT) != 0) begin : g_beat_check
      $error("chip8_frame_streamer: BEAT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [c_kw-1:0]    beat_q, beat_d;
  logic [c_total-1:0] shadow_q, shadow_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [7:0]         drop_count_q, drop_count_d;
  logic               snap_drop_q, snap_drop_d;
  logic               skip_now;
`ifdef CHIP8_FRAME_DIFF_EN
  logic               shadow_valid_q, shadow_valid_d;
  logic               frame_skip_q, frame_skip_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      shadow_q      <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      snap_drop_q   <= 1'b0;
`ifdef CHIP8_FRAME_DIFF_EN
      shadow_valid_q <= 1'b0;
      frame_skip_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      shadow_q      <= shadow_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      snap_drop_q   <= snap_drop_d;
`ifdef CHIP8_FRAME_DIFF_EN
      shadow_valid_q <= shadow_valid_d;
      frame_skip_q   <= frame_skip_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    shadow_d      = shadow_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    snap_drop_d   = 1'b0;
`ifdef CHIP8_FRAME_DIFF_EN
    // An unchanged display since the last capture is not worth re-sending.
    skip_now       = snap && (state_q == ST_IDLE) && shadow_valid_q && (display == shadow_q);
    shadow_valid_d = shadow_valid_q;
    frame_skip_d   = skip_now;
`else
    skip_now       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (snap && !skip_now) begin
          shadow_d      = display;
          beat_d        = '0;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = ST_STREAM;
`ifdef CHIP8_FRAME_DIFF_EN
          shadow_valid_d = 1'b1;
`endif
        end
      end
      ST_STREAM: begin
        if (snap) begin
          snap_drop_d = 1'b1;
          if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end
        if (out_ready) begin
          if (beat_q == c_last) begin
            beat_d  = '0;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + c_kw'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat k covers pixels k*BEAT .. k*BEAT+BEAT-1 in row-major order, MSB-first.
  always_comb begin
    out_valid = (state_q == ST_STREAM);
    busy      = out_valid;
    out_data  = '0;
    out_sof   = 1'b0;
    out_eol   = 1'b0;
    out_eof   = 1'b0;
    out_row   = '0;
    if (out_valid) begin
      out_data = shadow_q[c_total-1-(int'(beat_q)*BEAT) -: BEAT];
      out_sof  = (beat_q == '0);
      out_eol  = ((int'(beat_q) % c_bpr) == (c_bpr - 1));
      out_eof  = (beat_q == c_last);
      out_row  = c_rw'(int'(beat_q) / c_bpr);
    end
  end

  assign snap_drop   = snap_drop_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
`ifdef CHIP8_FRAME_DIFF_EN
  assign frame_skip  = frame_skip_q;
`endif

endmodule
`default_nettype wire
